// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge/response verifier.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    FINISH
  } state_e;

  localparam int unsigned MAX_CRP = 16;

  localparam logic [6:0] BASE_CHAL [MAX_CRP] = '{
    7'h13, 7'h2C, 7'h45, 7'h7A, 7'h06, 7'h59, 7'h31, 7'h6E,
    7'h1F, 7'h48, 7'h27, 7'h70, 7'h0B, 7'h54, 7'h3D, 7'h62
  };

endpackage

// File: rtl/puf_verifier_popcount8.sv
// Combinational Hamming weight of an 8-bit word.
module popcount8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, data_i[i]};
    end
  end

endmodule

// File: rtl/puf_verifier.sv
// Enrols a table of PUF responses and later verifies fresh responses against it
// by accumulated Hamming distance.
module puf_verifier
  import puf_pkg::*;
#(
  parameter int unsigned NUM_CRP       = 8,
  parameter int unsigned HD_THRESHOLD  = 6,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned RESP_TIMEOUT  = 32'h0A00_0000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ENROLL,
  output logic [7:0] PUF_CHALLENGE,
  input  logic [7:0] PUF_RESPONSE,
  input  logic       PUF_DONE,
  output logic       BUSY,
  output logic       RESULT_VALID,
  output logic       PASS,
  output logic       FAIL,
  output logic       ERROR,
  output logic       ENROLLED,
  output logic [6:0] HD_TOTAL
);

  localparam logic [3:0]  LastIdx  = 4'(NUM_CRP - 1);
  localparam logic [31:0] StartTmo = 32'(START_TIMEOUT);
  localparam logic [31:0] RespTmo  = 32'(RESP_TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic        mode_q, mode_d;
  logic [6:0]  hd_q, hd_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        err_q, err_d;
  logic        enrolled_q, enrolled_d;
  logic [7:0]  chal_q, chal_d;
  logic        par_q, par_d;
  logic        tbl_we;

  logic [7:0]  table_q [MAX_CRP];
  logic [3:0]  pc;
  logic [7:0]  hd_sum;
  logic [6:0]  hd_sat;

  popcount8 u_popcount (
    .data_i  (PUF_RESPONSE ^ table_q[idx_q]),
    .count_o (pc)
  );

  assign hd_sum = {1'b0, hd_q} + {4'b0000, pc};
  assign hd_sat = hd_sum[7] ? 7'h7F : hd_sum[6:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q + 32'd1;
    mode_d     = mode_q;
    hd_d       = hd_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_d      = err_q;
    enrolled_d = enrolled_q;
    chal_d     = chal_q;
    par_d      = par_q;
    tbl_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          mode_d = ENROLL;
          idx_d  = '0;
          hd_d   = '0;
          pass_d = 1'b0;
          fail_d = 1'b0;
          err_d  = 1'b0;
          if (ENROLL) begin
            enrolled_d = 1'b0;
          end
          if (!ENROLL && !enrolled_q) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Top bit forces the overall parity to flip so the PUF always sees a new request.
        chal_d  = {~par_q ^ (^BASE_CHAL[idx_q]), BASE_CHAL[idx_q]};
        par_d   = ~par_q;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!PUF_DONE) begin
          state_d = WAIT_DONE;
        end else if (tmo_q + 32'd1 >= StartTmo) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      WAIT_DONE: begin
        if (PUF_DONE) begin
          state_d = CAPTURE;
        end else if (tmo_q + 32'd1 >= RespTmo) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      CAPTURE: begin
        if (mode_q) begin
          tbl_we = 1'b1;
        end else begin
          hd_d = hd_sat;
        end
        if (idx_q == LastIdx) begin
          state_d = FINISH;
          if (mode_q) begin
            enrolled_d = 1'b1;
          end else begin
            pass_d = (32'(hd_d) <= HD_THRESHOLD);
            fail_d = ~pass_d;
          end
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ISSUE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      mode_q     <= 1'b0;
      hd_q       <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= 1'b0;
      enrolled_q <= 1'b0;
      chal_q     <= 8'h00;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      mode_q     <= mode_d;
      hd_q       <= hd_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      enrolled_q <= enrolled_d;
      chal_q     <= chal_d;
      par_q      <= par_d;
    end
  end

  // Table contents survive reset; ENROLLED alone marks them valid.
  always_ff @(posedge CLK) begin
    if (tbl_we) begin
      table_q[idx_q] <= PUF_RESPONSE;
    end
  end

  assign PUF_CHALLENGE = chal_q;
  assign BUSY          = (state_q != IDLE);
  assign RESULT_VALID  = (state_q == FINISH);
  assign PASS          = pass_q;
  assign FAIL          = fail_q;
  assign ERROR         = err_q;
  assign ENROLLED      = enrolled_q;
  assign HD_TOTAL      = hd_q;

endmodule

// File: tb/tb_puf_verifier.sv
// Self-checking bench for puf_verifier with a behavioural PUF and a result scoreboard.
module tb_puf_verifier;
  import puf_pkg::*;

  localparam int unsigned NumCrp   = 8;
  localparam int unsigned HdThr    = 6;
  localparam int unsigned StartTmo = 16;
  localparam int unsigned RespTmo  = 100;

  typedef struct packed {
    logic       err;
    logic       pass;
    logic       fail;
    logic       enr;
    logic [6:0] hd;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       ENROLL = 1'b0;
  logic [7:0] PUF_CHALLENGE;
  logic [7:0] PUF_RESPONSE;
  logic       PUF_DONE;
  logic       BUSY, RESULT_VALID, PASS, FAIL, ERROR, ENROLLED;
  logic [6:0] HD_TOTAL;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  // PUF model state
  logic       puf_done = 1'b1;
  logic [7:0] resp_q = 8'h00;
  logic       prev_par = 1'b0;
  int         phase = 0;
  int         cnt = 0;
  int         resp_num = 0;
  int         flip_n = 0;
  logic       never_lower = 1'b0;

  // Challenge recorder
  logic       rec_en = 1'b0;
  logic [7:0] last_chal = 8'h00;
  logic [7:0] chal_log[$];

  assign PUF_DONE     = puf_done;
  assign PUF_RESPONSE = resp_q;

  puf_verifier #(
    .NUM_CRP       (NumCrp),
    .HD_THRESHOLD  (HdThr),
    .START_TIMEOUT (StartTmo),
    .RESP_TIMEOUT  (RespTmo)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .ENROLL        (ENROLL),
    .PUF_CHALLENGE (PUF_CHALLENGE),
    .PUF_RESPONSE  (PUF_RESPONSE),
    .PUF_DONE      (PUF_DONE),
    .BUSY          (BUSY),
    .RESULT_VALID  (RESULT_VALID),
    .PASS          (PASS),
    .FAIL          (FAIL),
    .ERROR         (ERROR),
    .ENROLLED      (ENROLLED),
    .HD_TOTAL      (HD_TOTAL)
  );

  always #5 CLK = ~CLK;

  // DONE falls 2 cycles after a parity change, rises 50 cycles later.
  always @(posedge CLK) begin
    if (RESET) begin
      puf_done <= 1'b1;
      phase    <= 0;
      prev_par <= ^PUF_CHALLENGE;
      resp_num <= 0;
    end else begin
      prev_par <= ^PUF_CHALLENGE;
      if (START) resp_num <= 0;
      if ((^PUF_CHALLENGE) != prev_par) begin
        phase <= 1;
        cnt   <= 1;
      end else if (phase == 1) begin
        if (cnt == 0) begin
          if (never_lower) begin
            phase <= 0;
          end else begin
            puf_done <= 1'b0;
            phase    <= 2;
            cnt      <= 49;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end else if (phase == 2) begin
        if (cnt == 0) begin
          puf_done <= 1'b1;
          phase    <= 0;
          resp_q   <= PUF_CHALLENGE ^ 8'h5A ^ ((resp_num < flip_n) ? 8'h01 : 8'h00);
          resp_num <= resp_num + 1;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!rec_en) begin
      chal_log.delete();
      last_chal = PUF_CHALLENGE;
    end else if (PUF_CHALLENGE != last_chal) begin
      chal_log.push_back(PUF_CHALLENGE);
      last_chal = PUF_CHALLENGE;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic start_run(input logic enr, input logic push, input exp_t e);
    @(negedge CLK);
    if (push) sb_q.push_back(e);
    START  = 1'b1;
    ENROLL = enr;
    @(negedge CLK);
    START  = 1'b0;
    ENROLL = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int max, output int lat);
    exp_t e;
    lat = -1;
    for (int i = 0; i <= max; i++) begin
      if (RESULT_VALID) begin
        lat = i;
        break;
      end
      @(negedge CLK);
    end
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    if (lat < 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_error"}, 32'(ERROR), 32'(e.err));
    check({tag, "_pass"}, 32'(PASS), 32'(e.pass));
    check({tag, "_fail"}, 32'(FAIL), 32'(e.fail));
    check({tag, "_enrolled"}, 32'(ENROLLED), 32'(e.enr));
    check({tag, "_hd"}, 32'(HD_TOTAL), 32'(e.hd));
  endtask

  initial begin
    int   lat;
    logic p;
    logic [6:0] b;
    exp_t e;

    do_reset();
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_valid", 32'(RESULT_VALID), 32'd0);
    check("rst_pass", 32'(PASS), 32'd0);
    check("rst_fail", 32'(FAIL), 32'd0);
    check("rst_error", 32'(ERROR), 32'd0);
    check("rst_enrolled", 32'(ENROLLED), 32'd0);
    check("rst_hd", 32'(HD_TOTAL), 32'd0);
    check("rst_chal", 32'(PUF_CHALLENGE), 32'h00);

    // Verify before any enrolment
    e = '{err: 1'b1, pass: 1'b0, fail: 1'b0, enr: 1'b0, hd: 7'd0};
    start_run(1'b0, 1'b1, e);
    wait_result("noenr", 10, lat);
    check("noenr_latency_le2", 32'(lat >= 0 && lat <= 2), 32'd1);
    check("noenr_chal", 32'(PUF_CHALLENGE), 32'h00);

    // Enrol
    e = '{err: 1'b0, pass: 1'b0, fail: 1'b0, enr: 1'b1, hd: 7'd0};
    start_run(1'b1, 1'b1, e);
    check("run_busy", 32'(BUSY), 32'd1);
    wait_result("enrol", 1000, lat);

    // Clean verify
    flip_n = 0;
    e = '{err: 1'b0, pass: 1'b1, fail: 1'b0, enr: 1'b1, hd: 7'd0};
    start_run(1'b0, 1'b1, e);
    wait_result("verify0", 1000, lat);
    repeat (3) @(negedge CLK);
    check("pass_hold", 32'(PASS), 32'd1);

    // One bit flipped in every response
    flip_n = 8;
    e = '{err: 1'b0, pass: 1'b0, fail: 1'b1, enr: 1'b1, hd: 7'd8};
    start_run(1'b0, 1'b1, e);
    wait_result("verify8", 1000, lat);

    // Exactly at threshold
    flip_n = 6;
    e = '{err: 1'b0, pass: 1'b1, fail: 1'b0, enr: 1'b1, hd: 7'd6};
    start_run(1'b0, 1'b1, e);
    wait_result("verify6", 1000, lat);
    flip_n = 0;

    // PUF never goes busy during an enrol attempt
    never_lower = 1'b1;
    e = '{err: 1'b1, pass: 1'b0, fail: 1'b0, enr: 1'b0, hd: 7'd0};
    start_run(1'b1, 1'b1, e);
    wait_result("stuck", 100, lat);
    check("stuck_latency", 32'(lat >= int'(StartTmo) && lat <= int'(StartTmo) + 2), 32'd1);
    never_lower = 1'b0;
    repeat (5) @(negedge CLK);

    // Reset in the middle of WAIT_DONE, then restart
    start_run(1'b1, 1'b0, e);
    for (int i = 0; i < 100 && PUF_DONE; i++) @(negedge CLK);
    check("mid_done_low", 32'(PUF_DONE), 32'd0);
    repeat (5) @(negedge CLK);
    rec_en = 1'b0;
    do_reset();
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_enrolled", 32'(ENROLLED), 32'd0);
    @(negedge CLK);
    rec_en = 1'b1;
    e = '{err: 1'b0, pass: 1'b0, fail: 1'b0, enr: 1'b1, hd: 7'd0};
    start_run(1'b1, 1'b1, e);
    wait_result("restart", 1000, lat);
    check("restart_nchal", 32'(chal_log.size()), 32'(NumCrp));
    for (int i = 0; i < chal_log.size() && i < int'(NumCrp); i++) begin
      b = BASE_CHAL[i[3:0]];
      p = ((i % 2) == 0) ^ (^b);
      check($sformatf("restart_chal%0d", i), 32'(chal_log[i]), 32'({p, b}));
      if (i > 0) begin
        check($sformatf("restart_alt%0d", i), 32'(^chal_log[i] != ^chal_log[i-1]), 32'd1);
      end
    end

    repeat (2) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
